// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN datapath: FSM state type, accumulator sizing and saturation.
package dnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width that holds a sum of num_in products of in_w x w_w signed operands without overflow.
  function automatic int acc_width(input int in_w, input int w_w, input int num_in);
    return in_w + w_w + $clog2(num_in);
  endfunction

  // Clamp acc to the signed range of an out_w-bit value; the caller keeps the low out_w bits.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] acc, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/layer_mac.sv
// Signed multiply-accumulate: adds i_act*i_w each enabled cycle, clears after the last term.
module layer_mac #(
  parameter int IN_W  = 12,
  parameter int W_W   = 5,
  parameter int ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_last,
  input  logic signed [IN_W-1:0]  i_act,
  input  logic signed [W_W-1:0]   i_w,
  output logic signed [ACC_W-1:0] o_sum
);

  logic signed [IN_W+W_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod = i_act * i_w;
  assign o_sum  = r_acc + ACC_W'(w_prod);

  // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_last ? '0 : o_sum;
    end
  end

endmodule

// File: rtl/output_layer_seq.sv
// Time-multiplexed output layer: one MAC computes NUM_OUT saturated neurons with valid/ready on both sides.
// Define OUTPUT_LAYER_ARGMAX_EN to add the out_argmax port and its running-max tracker.
module output_layer_seq
  import dnn_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 2,
  parameter int IN_W    = 12,
  parameter int W_W     = 5,
  parameter int OUT_W   = 17
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_IN*IN_W-1:0]          in_vec,
  input  logic [NUM_OUT*NUM_IN*W_W-1:0]   weights,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_OUT*OUT_W-1:0]        out_vec
`ifdef OUTPUT_LAYER_ARGMAX_EN
  ,
  output logic [$clog2(NUM_OUT)-1:0]      out_argmax
`endif
);

  localparam int ACC_W = acc_width(IN_W, W_W, NUM_IN);
  localparam int I_W   = $clog2(NUM_IN);
  localparam int O_W   = $clog2(NUM_OUT);

  state_e                          r_state;
  state_e                          w_state_next;
  logic [I_W-1:0]                  r_i;
  logic [O_W-1:0]                  r_o;
  logic [NUM_IN*IN_W-1:0]          r_act;
  logic [NUM_OUT*NUM_IN*W_W-1:0]   r_w;
  logic [NUM_OUT*OUT_W-1:0]        r_res;
  logic                            w_accept;
  logic                            w_mac;
  logic                            w_last_i;
  logic                            w_last_o;
  logic signed [IN_W-1:0]          w_act;
  logic signed [W_W-1:0]           w_wt;
  logic signed [ACC_W-1:0]         w_sum;
  logic signed [OUT_W-1:0]         w_sat;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_mac    = (r_state == MAC);
  assign w_last_i = (r_i == I_W'(NUM_IN - 1));
  assign w_last_o = (r_o == O_W'(NUM_OUT - 1));
  assign w_act    = r_act[r_i*IN_W +: IN_W];
  assign w_wt     = r_w[(r_o*NUM_IN + r_i)*W_W +: W_W];
  assign w_sat    = OUT_W'(sat_to(64'(w_sum), OUT_W));
  assign out_vec  = r_res;

  layer_mac #(
    .IN_W  (IN_W),
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_mac),
    .i_last (w_last_i),
    .i_act  (w_act),
    .i_w    (w_wt),
    .o_sum  (w_sum)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = MAC;
      end
      MAC: begin
        if (w_last_i && w_last_o) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: captured operands and results are reset too, so nothing stale is visible after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_o     <= '0;
      r_act   <= '0;
      r_w     <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_act <= in_vec;
        r_w   <= weights;
        r_i   <= '0;
        r_o   <= '0;
      end else if (w_mac) begin
        if (w_last_i) begin
          r_i <= '0;
          r_o <= w_last_o ? '0 : r_o + O_W'(1);
          r_res[r_o*OUT_W +: OUT_W] <= w_sat;
        end else begin
          r_i <= r_i + I_W'(1);
        end
      end
    end
  end

`ifdef OUTPUT_LAYER_ARGMAX_EN
  logic signed [OUT_W-1:0] r_max;
  logic [O_W-1:0]          r_argmax;

  assign out_argmax = r_argmax;

  // Strict greater-than keeps the lowest index on ties; neuron 0 always seeds the max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max    <= '0;
      r_argmax <= '0;
    end else if (w_mac && w_last_i) begin
      if ((r_o == '0) || (w_sat > r_max)) begin
        r_max    <= w_sat;
        r_argmax <= r_o;
      end
    end
  end
`endif

endmodule

// File: tb/tb_output_layer_seq.sv
// Directed self-checking bench for output_layer_seq at default parameters.
module tb_output_layer_seq;

  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 2;
  localparam int IN_W    = 12;
  localparam int W_W     = 5;
  localparam int OUT_W   = 17;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          in_valid = 1'b0;
  logic                          in_ready;
  logic [NUM_IN*IN_W-1:0]        in_vec = '0;
  logic [NUM_OUT*NUM_IN*W_W-1:0] weights = '0;
  logic                          out_valid;
  logic                          out_ready = 1'b0;
  logic [NUM_OUT*OUT_W-1:0]      out_vec;
`ifdef OUTPUT_LAYER_ARGMAX_EN
  logic [$clog2(NUM_OUT)-1:0]    out_argmax;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  output_layer_seq #(
    .NUM_IN  (NUM_IN),
    .NUM_OUT (NUM_OUT),
    .IN_W    (IN_W),
    .W_W     (W_W),
    .OUT_W   (OUT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .weights    (weights),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec)
`ifdef OUTPUT_LAYER_ARGMAX_EN
    ,
    .out_argmax (out_argmax)
`endif
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_IN*IN_W-1:0] pv(input int a0, input int a1, input int a2, input int a3);
    return {12'(a3), 12'(a2), 12'(a1), 12'(a0)};
  endfunction

  function automatic logic [NUM_OUT*NUM_IN*W_W-1:0] pw(input int w00, input int w01, input int w02,
                                                       input int w03, input int w10, input int w11,
                                                       input int w12, input int w13);
    return {5'(w13), 5'(w12), 5'(w11), 5'(w10), 5'(w03), 5'(w02), 5'(w01), 5'(w00)};
  endfunction

  function automatic int res(input int o);
    logic signed [OUT_W-1:0] v;
    v = out_vec[o*OUT_W +: OUT_W];
    return int'(v);
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after the accept edge with inputs scrambled.
  task automatic send(input logic [NUM_IN*IN_W-1:0] v, input logic [NUM_OUT*NUM_IN*W_W-1:0] w);
    in_vec   = v;
    weights  = w;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_vec   = ~v;
    weights  = ~w;
  endtask

  // Counts negedges after the accept edge until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_vld_low"}, 32'(out_valid), 0);
    check({tag, "_rdy_high"}, 32'(in_ready), 1);
  endtask

  task automatic run_vec(input string tag, input logic [NUM_IN*IN_W-1:0] v,
                         input logic [NUM_OUT*NUM_IN*W_W-1:0] w,
                         input int e0, input int e1, input int am);
    int lat;
    send(v, w);
    wait_out(lat);
    check({tag, "_lat"}, lat, 9);
    check({tag, "_o0"}, res(0), e0);
    check({tag, "_o1"}, res(1), e1);
`ifdef OUTPUT_LAYER_ARGMAX_EN
    check({tag, "_am"}, 32'(out_argmax), am);
`else
    if (am < 0) $display("unexpected argmax index %0d", am);
`endif
    drain(tag);
  endtask

  initial begin
    int lat;
    int stale;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_out_valid", 32'(out_valid), 0);
    check("rel_in_ready", 32'(in_ready), 1);
    check("rel_o0", res(0), 0);
    check("rel_o1", res(1), 0);

    run_vec("basic", pv(1, 2, 3, 4), pw(1, 1, 1, 1, -1, -1, -1, -1), 10, -10, 0);
    run_vec("sat_pos", pv(2047, 2047, 2047, 2047), pw(15, 15, 15, 15, -16, -16, -16, -16),
            65535, -65536, 0);
    run_vec("sat_neg", pv(-2048, -2048, -2048, -2048), pw(-16, -16, -16, -16, 15, 15, 15, 15),
            65535, -65536, 0);
    run_vec("mixed", pv(5, -3, 7, -2), pw(2, -1, 0, 3, 4, -5, 1, 1), 7, 40, 1);

    // Backpressure with a pending vector held by the producer.
    send(pv(10, 20, 30, 40), pw(1, 1, 1, 1, -1, 0, 0, 1));
    wait_out(lat);
    check("bp_lat", lat, 9);
    in_vec   = pv(1, 1, 1, 1);
    weights  = pw(3, 3, 3, 3, 2, 2, 2, 2);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_vld", 32'(out_valid), 1);
      check("bp_in_rdy", 32'(in_ready), 0);
      check("bp_o0", res(0), 100);
      check("bp_o1", res(1), 30);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_hs_vld", 32'(out_valid), 0);
    check("bp_hs_rdy", 32'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_acc_rdy", 32'(in_ready), 0);
    wait_out(lat);
    check("bp2_lat", lat, 9);
    check("bp2_o0", res(0), 12);
    check("bp2_o1", res(1), 8);
    drain("bp2");

    // Reset four edges after accept, in the middle of MAC.
    in_vec   = pv(100, 100, 100, 100);
    weights  = pw(5, 5, 5, 5, 6, 6, 6, 6);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_vld", 32'(out_valid), 0);
    check("mrst_rdy", 32'(in_ready), 1);
    check("mrst_o0", res(0), 0);
    check("mrst_o1", res(1), 0);
`ifdef OUTPUT_LAYER_ARGMAX_EN
    check("mrst_am", 32'(out_argmax), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_rel_rdy", 32'(in_ready), 1);
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("mrst_stale", stale, 0);
    run_vec("post_rst", pv(1, 2, 3, 4), pw(2, 2, 2, 2, 1, 0, 0, 1), 20, 5, 0);

    run_vec("tie", pv(1, 2, 3, 31), pw(1, 1, 1, 1, 1, 1, 1, 1), 37, 37, 0);
    run_vec("tie_plus1", pv(1, 2, 3, 31), pw(1, 1, 1, 1, 2, 1, 1, 1), 37, 38, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "simulation did not finish");
  end

endmodule

// File: doc/output_layer_seq.md
# output_layer_seq

Parametrised, time-multiplexed output layer for the DNN datapath. One signed multiply-accumulate unit computes NUM_OUT neurons, each a weighted sum of NUM_IN activations. Each neuron result is saturated to OUT_W bits. The block sits after the last hidden layer and replaces the fixed 4-input, 2-output parallel layer. It uses a valid/ready handshake on both sides instead of one-shot ready pulses.

## Interface
Parameters:
- NUM_IN, 4, activations per neuron (≥2)
- NUM_OUT, 2, neurons in the layer (≥2)
- IN_W, 12, signed activation width
- W_W, 5, signed weight width
- OUT_W, 17, signed result width after saturation

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  activation vector valid
- in_ready  out  1  block can accept a vector
- in_vec  in  NUM_IN*IN_W  signed activations; element i at bits [i*IN_W +: IN_W]
- weights  in  NUM_OUT*NUM_IN*W_W  signed weights; weight (o,i) at [(o*NUM_IN+i)*W_W +: W_W]; quasi-static
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts result
- out_vec  out  NUM_OUT*OUT_W  signed saturated results; neuron o at [o*OUT_W +: OUT_W]
- out_argmax  out  $clog2(NUM_OUT)  index of largest result (only with OUTPUT_LAYER_ARGMAX_EN)

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - MAC: iterates neuron o from 0 to NUM_OUT-1 and input i from 0 to NUM_IN-1, i innermost.
  - DONE: out_valid=1.
- IDLE→MAC when in_valid&&in_ready.
  - in_vec and weights are registered into internal copies on the accept edge.
  - Later changes on either port are ignored until the next accept.
- MAC performs one product per cycle: acc += act[i]*w[o][i].
  - ACC_W = IN_W+W_W+$clog2(NUM_IN). With defaults, ACC_W is 19. The accumulator cannot overflow.
  - On the last i of a neuron, the accumulator is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and written to result register o.
  - The accumulator then clears for the next neuron.
- MAC→DONE after neuron NUM_OUT-1, input NUM_IN-1.
- DONE→IDLE when out_valid&&out_ready. out_vec stays stable for as long as DONE lasts.
- in_ready=0 in MAC and DONE. An in_valid presented then is not accepted and must be held by the producer.
- Reset (asynchronous, at any time, including mid-MAC):
  - state←IDLE, counters and accumulator←0, out_vec←0, out_argmax←0.
  - out_valid←0, in_ready←1 after reset deasserts.
  - A partial computation is discarded and never emitted.

## Timing
- Accept at edge T.
- MAC occupies cycles T+1 … T+NUM_IN*NUM_OUT.
- out_valid rises at T+NUM_IN*NUM_OUT+1. With defaults, that is T+9.
- Minimum vector period: NUM_IN*NUM_OUT+2 cycles. That is one accept cycle, the MAC cycles, and one DONE cycle with out_ready=1.
- All outputs are registered. No combinational path exists from in_valid/out_ready to any output except in_ready, which is decoded from state only.

## Configuration
- OUTPUT_LAYER_ARGMAX_EN
  - Defined: the block adds the out_argmax port and a running-max register updated as each neuron result is written.
    - out_argmax is valid with out_valid.
    - On a tie, the lowest index wins.
    - Argmax compares the saturated values.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package dnn_pkg holds:
  - Function clog2-based ACC_W helper.
  - Saturation function sat_to(acc, OUT_W).
  - FSM state enum typedef (IDLE, MAC, DONE).
- One sub-module, layer_mac, implements the signed multiply, accumulate and clear-on-last. Its parameters are IN_W, W_W and ACC_W.

## Test plan
- Basic result (defaults):
  - in_vec=(1,2,3,4), neuron 0 weights all +1, neuron 1 weights all -1.
  - Required: out_vec=(10,-10) and out_valid exactly 9 cycles after accept.
  - With OUTPUT_LAYER_ARGMAX_EN: out_argmax=0.
- Saturation:
  - all inputs 2047 with neuron 0 weights 15 → 122820, saturated to 65535.
  - all inputs 2047 with neuron 1 weights -16 → -131008, saturated to -65536.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Required: out_vec stable, in_ready=0, and a pending in_valid is not accepted until the cycle after out_ready=1.
- Input isolation: change in_vec and weights on the cycle after accept. Required: results match the values captured at accept.
- Reset mid-MAC: assert rst_n=0 at T+4. Required: out_valid=0, out_vec=0, in_ready=1 after release, and no stale result is emitted. The next vector computes correctly.
- Argmax tie (macro on): both neurons produce 37. Required: out_argmax=0. With neuron 1 at 38: out_argmax=1.
